dcpu_bus_ctrl: RTL and testbench

//  Memory-side end of the CPU address path: takes the 16-bit address the register file drives

---
 rtl/dcpu_bus_ctrl.sv | 170 +++++++++++++++++
 tb/tb_dcpu_bus_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcpu_bus_ctrl.sv
// Memory-side bus controller: latches a core request and runs 1- or 2-byte strobe/ack cycles.
// Latency: zero-wait 1-byte done 2 cycles after request, 2-byte 4 cycles; +1 per wait cycle.
// Backpressure: requests are ignored while o_busy=1; memory stalls by withholding i_mem_ack.
module dcpu_bus_ctrl #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        i_reset,
   input  logic        i_req,
   input  logic        i_we,
   input  logic        i_wide,
   input  logic [15:0] i_addr,
   input  logic [15:0] i_wdat,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_err,
   output logic [15:0] o_rdat,
   output logic        o_mem_cs,
   output logic        o_mem_we,
   output logic [15:0] o_mem_addr,
   output logic [7:0]  o_mem_wdat,
   input  logic [7:0]  i_mem_dat,
   input  logic        i_mem_ack
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_GAP    = 2'd2
   } state_t;

   // Timeout compare value; unused when TIMEOUT=0 (abort disabled).
   localparam bit          TO_EN   = (TIMEOUT != 0);
   localparam logic [7:0]  TO_LAST = 8'(TIMEOUT - 1);

   state_t      r_state,     w_state_nx;
   logic        r_wide,      w_wide_nx;
   logic        r_second,    w_second_nx;   // currently transferring the high byte
   logic [7:0]  r_wdat_hi,   w_wdat_hi_nx;  // high write byte held until the second strobe
   logic [7:0]  r_cnt,       w_cnt_nx;      // ACCESS cycles without ack in this strobe
   logic        r_busy,      w_busy_nx;
   logic        r_done,      w_done_nx;
   logic        r_err,       w_err_nx;
   logic [15:0] r_rdat,      w_rdat_nx;
   logic        r_mem_cs,    w_mem_cs_nx;
   logic        r_mem_we,    w_mem_we_nx;
   logic [15:0] r_mem_addr,  w_mem_addr_nx;
   logic [7:0]  r_mem_wdat,  w_mem_wdat_nx;

   // Next-state and registered-output decode; everything holds unless a transition updates it.
   always_comb begin
      w_state_nx    = r_state;
      w_wide_nx     = r_wide;
      w_second_nx   = r_second;
      w_wdat_hi_nx  = r_wdat_hi;
      w_cnt_nx      = r_cnt;
      w_busy_nx     = r_busy;
      w_done_nx     = 1'b0;
      w_err_nx      = 1'b0;
      w_rdat_nx     = r_rdat;
      w_mem_cs_nx   = r_mem_cs;
      w_mem_we_nx   = r_mem_we;
      w_mem_addr_nx = r_mem_addr;
      w_mem_wdat_nx = r_mem_wdat;

      case (r_state)
         S_IDLE: begin
            if (i_req) begin
               w_wide_nx     = i_wide;
               w_second_nx   = 1'b0;
               w_wdat_hi_nx  = i_wdat[15:8];
               w_cnt_nx      = 8'd0;
               w_busy_nx     = 1'b1;
               w_mem_cs_nx   = 1'b1;
               w_mem_we_nx   = i_we;
               w_mem_addr_nx = i_addr;
               w_mem_wdat_nx = i_wdat[7:0];
               w_state_nx    = S_ACCESS;
            end
         end

         S_ACCESS: begin
            if (i_mem_ack) begin
               // Ack beats a timeout landing on the same cycle.
               if (!r_mem_we) begin
                  if (r_second) begin
                     w_rdat_nx[15:8] = i_mem_dat;
                  end else begin
                     w_rdat_nx[7:0] = i_mem_dat;
                  end
               end
               w_mem_cs_nx = 1'b0;
               if (r_wide && !r_second) begin
                  w_second_nx   = 1'b1;
                  w_mem_addr_nx = r_mem_addr + 16'd1;
                  w_mem_wdat_nx = r_wdat_hi;
                  w_state_nx    = S_GAP;
               end else begin
                  w_busy_nx  = 1'b0;
                  w_done_nx  = 1'b1;
                  w_state_nx = S_IDLE;
               end
            end else if (TO_EN && (r_cnt == TO_LAST)) begin
               w_mem_cs_nx = 1'b0;
               w_busy_nx   = 1'b0;
               w_done_nx   = 1'b1;
               w_err_nx    = 1'b1;
               w_state_nx  = S_IDLE;
            end else if (TO_EN) begin
               w_cnt_nx = r_cnt + 8'd1;
            end
         end

         S_GAP: begin
            w_mem_cs_nx = 1'b1;
            w_cnt_nx    = 8'd0;
            w_state_nx  = S_ACCESS;
         end

         default: begin
            w_state_nx  = S_IDLE;
            w_mem_cs_nx = 1'b0;
            w_busy_nx   = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (i_reset) begin
         r_state    <= S_IDLE;
         r_wide     <= 1'b0;
         r_second   <= 1'b0;
         r_wdat_hi  <= 8'd0;
         r_cnt      <= 8'd0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
         r_rdat     <= 16'd0;
         r_mem_cs   <= 1'b0;
         r_mem_we   <= 1'b0;
         r_mem_addr <= 16'd0;
         r_mem_wdat <= 8'd0;
      end else begin
         r_state    <= w_state_nx;
         r_wide     <= w_wide_nx;
         r_second   <= w_second_nx;
         r_wdat_hi  <= w_wdat_hi_nx;
         r_cnt      <= w_cnt_nx;
         r_busy     <= w_busy_nx;
         r_done     <= w_done_nx;
         r_err      <= w_err_nx;
         r_rdat     <= w_rdat_nx;
         r_mem_cs   <= w_mem_cs_nx;
         r_mem_we   <= w_mem_we_nx;
         r_mem_addr <= w_mem_addr_nx;
         r_mem_wdat <= w_mem_wdat_nx;
      end
   end

   assign o_busy     = r_busy;
   assign o_done     = r_done;
   assign o_err      = r_err;
   assign o_rdat     = r_rdat;
   assign o_mem_cs   = r_mem_cs;
   assign o_mem_we   = r_mem_we;
   assign o_mem_addr = r_mem_addr;
   assign o_mem_wdat = r_mem_wdat;

endmodule

// File: tb/tb_dcpu_bus_ctrl.sv
// Bench for dcpu_bus_ctrl: directed cases then randomized transfers against a transaction model.
// A memory responder acks each strobe after a programmed number of wait cycles.
// Expected latency, error, read data and byte sequence come from per-byte wait arithmetic.
module tb_dcpu_bus_ctrl;
   localparam int unsigned TO = 4;

   logic        clk;
   logic        i_reset;
   logic        i_req;
   logic        i_we;
   logic        i_wide;
   logic [15:0] i_addr;
   logic [15:0] i_wdat;
   logic        o_busy;
   logic        o_done;
   logic        o_err;
   logic [15:0] o_rdat;
   logic        o_mem_cs;
   logic        o_mem_we;
   logic [15:0] o_mem_addr;
   logic [7:0]  o_mem_wdat;
   logic [7:0]  i_mem_dat;
   logic        i_mem_ack;

   dcpu_bus_ctrl #(.TIMEOUT(TO)) dut (
      .clk        (clk),
      .i_reset    (i_reset),
      .i_req      (i_req),
      .i_we       (i_we),
      .i_wide     (i_wide),
      .i_addr     (i_addr),
      .i_wdat     (i_wdat),
      .o_busy     (o_busy),
      .o_done     (o_done),
      .o_err      (o_err),
      .o_rdat     (o_rdat),
      .o_mem_cs   (o_mem_cs),
      .o_mem_we   (o_mem_we),
      .o_mem_addr (o_mem_addr),
      .o_mem_wdat (o_mem_wdat),
      .i_mem_dat  (i_mem_dat),
      .i_mem_ack  (i_mem_ack)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_cmp;
   int n_mis;

   // Responder programming and observed strobes ({addr, we, wdat}), one entry per strobe.
   int          resp_wait [2];
   logic [7:0]  resp_dat  [2];
   logic [24:0] bus_q [$];
   int          stab_err;
   int          q_rd;
   logic [15:0] exp_rdat;

   int          rs_cyc;
   int          rs_idx;
   logic        rs_prev_cs;
   logic [24:0] rs_cur;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Memory responder: ack after resp_wait cycles of strobe; junk on ack/dat while strobe is low.
   initial begin
      i_mem_ack  = 1'b0;
      i_mem_dat  = 8'd0;
      rs_cyc     = 0;
      rs_idx     = 0;
      rs_prev_cs = 1'b0;
      rs_cur     = '0;
      stab_err   = 0;
      forever begin
         @(negedge clk);
         if (o_mem_cs) begin
            if (!rs_prev_cs) begin
               rs_cur = {o_mem_addr, o_mem_we, o_mem_wdat};
               bus_q.push_back(rs_cur);
               rs_cyc = 0;
            end else if ({o_mem_addr, o_mem_we, o_mem_wdat} !== rs_cur) begin
               stab_err++;
            end
            if (rs_cyc == resp_wait[rs_idx]) begin
               i_mem_ack = 1'b1;
               i_mem_dat = resp_dat[rs_idx];
            end else begin
               i_mem_ack = 1'b0;
               i_mem_dat = 8'($urandom);
            end
            rs_cyc++;
         end else begin
            if (!o_busy) rs_idx = 0;
            else if (rs_prev_cs) rs_idx = 1;
            i_mem_ack = 1'($urandom);
            i_mem_dat = 8'($urandom);
         end
         rs_prev_cs = o_mem_cs;
      end
   end

   // One transfer: present request, scramble inputs while busy, check the result at o_done.
   task automatic run_txn(input logic we, input logic wide, input logic [15:0] addr,
                          input logic [15:0] wdat, input int w0, input int w1,
                          input logic [7:0] d0, input logic [7:0] d1,
                          input bit at_neg, input bit chain, input string tag);
      bit          ok0, ok1, exp_err;
      int          exp_k, k, nbytes, got;
      logic [24:0] exp_b [2];
      logic [15:0] a1;
      if (!at_neg) @(negedge clk);
      resp_wait[0] = w0;
      resp_wait[1] = w1;
      resp_dat[0]  = d0;
      resp_dat[1]  = d1;
      i_req  = 1'b1;
      i_we   = we;
      i_wide = wide;
      i_addr = addr;
      i_wdat = wdat;

      // Model: each byte costs (waits+1) cycles if acked in time, else TO cycles and aborts.
      ok0    = (w0 < int'(TO));
      ok1    = 1'b0;
      exp_k  = 1 + (ok0 ? w0 + 1 : int'(TO));
      nbytes = 1;
      a1     = addr + 16'd1;
      exp_b[0] = {addr, we, wdat[7:0]};
      exp_b[1] = {a1, we, wdat[15:8]};
      if (wide && ok0) begin
         ok1    = (w1 < int'(TO));
         exp_k  = exp_k + 1 + (ok1 ? w1 + 1 : int'(TO));
         nbytes = 2;
      end
      exp_err = !(ok0 && (!wide || ok1));
      if (!we) begin
         if (ok0) exp_rdat[7:0]  = d0;
         if (ok1) exp_rdat[15:8] = d1;
      end

      k = 0;
      while (k < 60) begin
         @(posedge clk);
         @(negedge clk);
         k++;
         if (o_done) break;
         i_req  = 1'($urandom);
         i_we   = 1'($urandom);
         i_wide = 1'($urandom);
         i_addr = 16'($urandom);
         i_wdat = 16'($urandom);
      end
      check({tag, "/latency"}, k, exp_k);
      check({tag, "/err"}, {31'd0, o_err}, {31'd0, exp_err});
      check({tag, "/busy_at_done"}, {31'd0, o_busy}, 32'd0);
      check({tag, "/rdat"}, {16'd0, o_rdat}, {16'd0, exp_rdat});
      got = bus_q.size() - q_rd;
      check({tag, "/strobes"}, got, nbytes);
      for (int i = 0; i < nbytes; i++) begin
         if (q_rd + i < bus_q.size())
            check({tag, "/strobe_cmd"}, {7'd0, bus_q[q_rd + i]}, {7'd0, exp_b[i]});
      end
      q_rd = bus_q.size();
      if (!chain) begin
         i_req = 1'b0;
         @(negedge clk);
         check({tag, "/done_single"}, {31'd0, o_done}, 32'd0);
         check({tag, "/idle_cs"}, {31'd0, o_mem_cs}, 32'd0);
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit prev_chain;
      bit ch;
      n_cmp     = 0;
      n_mis     = 0;
      q_rd      = 0;
      exp_rdat  = 16'd0;
      resp_wait[0] = 0;
      resp_wait[1] = 0;
      resp_dat[0]  = 8'd0;
      resp_dat[1]  = 8'd0;
      i_reset = 1'b1;
      i_req   = 1'b0;
      i_we    = 1'b0;
      i_wide  = 1'b0;
      i_addr  = 16'd0;
      i_wdat  = 16'd0;
      repeat (3) @(negedge clk);

      check("rst/busy",  {31'd0, o_busy},   32'd0);
      check("rst/done",  {31'd0, o_done},   32'd0);
      check("rst/err",   {31'd0, o_err},    32'd0);
      check("rst/cs",    {31'd0, o_mem_cs}, 32'd0);
      check("rst/we",    {31'd0, o_mem_we}, 32'd0);
      check("rst/addr",  {16'd0, o_mem_addr}, 32'd0);
      check("rst/wdat",  {24'd0, o_mem_wdat}, 32'd0);
      check("rst/rdat",  {16'd0, o_rdat},   32'd0);
      i_reset = 1'b0;
      q_rd = bus_q.size();

      // Directed cases.
      run_txn(1'b0, 1'b0, 16'h1234, 16'h0000, 0, 0, 8'hA5, 8'h00, 1'b0, 1'b0, "rd1");
      run_txn(1'b1, 1'b1, 16'hFFFF, 16'hBEEF, 2, 2, 8'h11, 8'h22, 1'b0, 1'b0, "wr_wrap");
      run_txn(1'b0, 1'b1, 16'h0100, 16'h0000, 0, 1, 8'h34, 8'h12, 1'b0, 1'b0, "rd_wide");
      run_txn(1'b0, 1'b0, 16'h2000, 16'h0000, 100, 0, 8'h77, 8'h00, 1'b0, 1'b0, "timeout");
      run_txn(1'b0, 1'b1, 16'h3000, 16'h0000, 0, 9, 8'h5A, 8'h66, 1'b0, 1'b0, "timeout_b1");
      run_txn(1'b0, 1'b0, 16'h4000, 16'h0000, int'(TO) - 1, 0, 8'hC3, 8'h00, 1'b0, 1'b0, "ack_last");
      run_txn(1'b1, 1'b0, 16'h5000, 16'hAB99, 1, 0, 8'hEE, 8'h00, 1'b0, 1'b0, "wr_keeps_rdat");

      // Reset during the first strobe of a wide read.
      @(negedge clk);
      resp_wait[0] = 3;
      resp_wait[1] = 3;
      i_req  = 1'b1;
      i_we   = 1'b0;
      i_wide = 1'b1;
      i_addr = 16'h6000;
      @(negedge clk);
      i_req = 1'b0;
      @(negedge clk);
      check("mid_rst/cs_before", {31'd0, o_mem_cs}, 32'd1);
      i_reset = 1'b1;
      @(negedge clk);
      i_reset = 1'b0;
      check("mid_rst/busy", {31'd0, o_busy},   32'd0);
      check("mid_rst/done", {31'd0, o_done},   32'd0);
      check("mid_rst/err",  {31'd0, o_err},    32'd0);
      check("mid_rst/cs",   {31'd0, o_mem_cs}, 32'd0);
      check("mid_rst/addr", {16'd0, o_mem_addr}, 32'd0);
      check("mid_rst/rdat", {16'd0, o_rdat},   32'd0);
      exp_rdat = 16'd0;
      @(negedge clk);
      check("mid_rst/no_done", {31'd0, o_done}, 32'd0);
      q_rd = bus_q.size();
      run_txn(1'b0, 1'b1, 16'h6000, 16'h0000, 0, 0, 8'h9C, 8'hD1, 1'b0, 1'b0, "after_rst");

      // Back-to-back: second request presented in the o_done cycle of the first.
      run_txn(1'b1, 1'b0, 16'h7000, 16'h0042, 0, 0, 8'h00, 8'h00, 1'b0, 1'b1, "b2b_a");
      run_txn(1'b0, 1'b1, 16'h7001, 16'h0000, 0, 0, 8'h4E, 8'h8F, 1'b1, 1'b0, "b2b_b");

      // Randomized transfers, some chained back-to-back.
      prev_chain = 1'b0;
      for (int t = 0; t < 40; t++) begin
         ch = ($urandom_range(0, 3) == 0);
         run_txn(1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom),
                 int'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
                 8'($urandom), 8'($urandom), prev_chain, ch, "rand");
         prev_chain = ch;
      end
      if (prev_chain) begin
         i_req = 1'b0;
         @(negedge clk);
      end

      check("strobe_stability", stab_err, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
